alu_op_issuer: RTL

Command-issue stage directly upstream of the ALU. Accepts ALU operations over a valid/ready stream, buffers them in a small FIFO, and drives the ALU input pins (`ce`, `inp_valid`, `mode`, `cmd`, `opa`, `opb`, `cin`) one operation at a time. It holds each operation stable for the ALU's command-dependent latency, then pulses `res_strobe` in the cycle the ALU outputs are valid, so downstream capture logic and the monitor know when to sample.

---
 rtl/alu_issue_pkg.sv | 45 ++++
 rtl/alu_op_issuer_if.sv | 45 ++++
 rtl/alu_issue_fifo.sv | 67 ++++++
 rtl/alu_op_issuer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// +----------------------------------------------------------------------+
// | alu_issue_pkg                                                        |
// | Shared types, constants and latency helper for the ALU issue stage.  |
// | Optional macro: ALU_ISSUE_SPLIT_EN (adds the SPLIT state)            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

package alu_issue_pkg;

  localparam logic [3:0] CMD_MUL_INC = 4'd9;
  localparam logic [3:0] CMD_MUL_SHL = 4'd10;
  localparam logic [1:0] LAT_MUL     = 2'd2;
  localparam logic [1:0] LAT_DEF     = 2'd1;

`ifdef ALU_ISSUE_SPLIT_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    SPLIT = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;
`endif

  // Control part of a FIFO entry; operands are appended by the issuer.
  typedef struct packed {
    logic       mode;
    logic [3:0] cmd;
    logic       cin;
    logic [1:0] inp_valid;
  } entry_ctrl_t;

  function automatic logic [1:0] op_latency(input logic mode, input logic [3:0] cmd);
    return (mode && (cmd == CMD_MUL_INC || cmd == CMD_MUL_SHL)) ? LAT_MUL : LAT_DEF;
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_op_issuer_if.sv
// +----------------------------------------------------------------------+
// | alu_op_issuer_if                                                     |
// | Upstream op stream plus ALU pin bundle of the issue stage.           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

interface alu_op_issuer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  logic                   in_valid;
  logic                   in_ready;
  logic                   in_mode;
  logic                   in_cin;
  logic [3:0]             in_cmd;
  logic [1:0]             in_inp_valid;
  logic [WIDTH-1:0]       in_opa;
  logic [WIDTH-1:0]       in_opb;

  logic                   ce;
  logic                   mode;
  logic                   cin;
  logic [3:0]             cmd;
  logic [1:0]             inp_valid;
  logic [WIDTH-1:0]       opa;
  logic [WIDTH-1:0]       opb;
  logic                   res_strobe;
  logic                   busy;
  logic [$clog2(DEPTH):0] fifo_count;

  modport master (
    output in_valid, in_mode, in_cin, in_cmd, in_inp_valid, in_opa, in_opb,
    input  in_ready, ce, mode, cin, cmd, inp_valid, opa, opb,
    input  res_strobe, busy, fifo_count
  );

  modport slave (
    input  in_valid, in_mode, in_cin, in_cmd, in_inp_valid, in_opa, in_opb,
    output in_ready, ce, mode, cin, cmd, inp_valid, opa, opb,
    output res_strobe, busy, fifo_count
  );
endinterface

`default_nettype wire

// File: rtl/alu_issue_fifo.sv
// +----------------------------------------------------------------------+
// | alu_issue_fifo                                                       |
// | Show-ahead synchronous FIFO with full, empty and occupancy count.    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_issue_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int c_ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [c_ADDR_W-1:0] r_wr_ptr;
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [c_ADDR_W:0]   r_count;
  logic                w_push_ok;
  logic                w_pop_ok;

  assign full      = (r_count == (c_ADDR_W+1)'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign rd_data   = r_mem[r_rd_ptr];
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;

  // Storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_op_issuer.sv
// +----------------------------------------------------------------------+
// | alu_op_issuer                                                        |
// | Buffers ALU ops and drives the ALU pins with latency-timed strobe.   |
// | Optional macro: ALU_ISSUE_SPLIT_EN (two-phase operand presentation)  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_op_issuer
  import alu_issue_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  alu_op_issuer_if.slave bus
);
  localparam int c_CTRL_W  = $bits(entry_ctrl_t);
  localparam int c_ENTRY_W = c_CTRL_W + 2*WIDTH;
  localparam int c_CNT_W   = $clog2(DEPTH) + 1;

  entry_ctrl_t          w_wr_ctrl;
  entry_ctrl_t          w_rd_ctrl;
  logic [c_ENTRY_W-1:0] w_wr_data;
  logic [c_ENTRY_W-1:0] w_rd_data;
  logic [WIDTH-1:0]     w_rd_opa;
  logic [WIDTH-1:0]     w_rd_opb;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic [c_CNT_W-1:0]   w_count;

  state_t               r_state;
  logic [1:0]           r_cnt;
  logic                 r_ce;
  logic                 r_mode;
  logic                 r_cin;
  logic [3:0]           r_cmd;
  logic [1:0]           r_inp_valid;
  logic [WIDTH-1:0]     r_opa;
  logic [WIDTH-1:0]     r_opb;
  logic                 r_strobe;
`ifdef ALU_ISSUE_SPLIT_EN
  logic [WIDTH-1:0]     r_opb_hold;
`endif

  always_comb begin
    w_wr_ctrl           = '0;
    w_wr_ctrl.mode      = bus.in_mode;
    w_wr_ctrl.cmd       = bus.in_cmd;
    w_wr_ctrl.cin       = bus.in_cin;
    w_wr_ctrl.inp_valid = bus.in_inp_valid;
  end

  assign w_wr_data = {w_wr_ctrl, bus.in_opa, bus.in_opb};
  assign w_rd_ctrl = entry_ctrl_t'(w_rd_data[c_ENTRY_W-1 -: c_CTRL_W]);
  assign w_rd_opa  = w_rd_data[2*WIDTH-1 -: WIDTH];
  assign w_rd_opb  = w_rd_data[WIDTH-1:0];
  assign w_push    = bus.in_valid && !w_full;
  // A new op is taken only from IDLE or in the strobe cycle of the previous one.
  assign w_pop     = !w_empty && (r_state == IDLE || r_strobe);

  alu_issue_fifo #(
    .WIDTH (c_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (w_push),
    .wr_data (w_wr_data),
    .pop     (w_pop),
    .rd_data (w_rd_data),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_ce        <= 1'b0;
      r_mode      <= 1'b0;
      r_cin       <= 1'b0;
      r_cmd       <= '0;
      r_inp_valid <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_strobe    <= 1'b0;
`ifdef ALU_ISSUE_SPLIT_EN
      r_opb_hold  <= '0;
`endif
    end else begin
      r_strobe <= 1'b0;
      if (w_pop) begin
        r_ce   <= 1'b1;
        r_mode <= w_rd_ctrl.mode;
        r_cmd  <= w_rd_ctrl.cmd;
        r_cin  <= w_rd_ctrl.cin;
        r_opa  <= w_rd_opa;
        r_cnt  <= op_latency(w_rd_ctrl.mode, w_rd_ctrl.cmd);
`ifdef ALU_ISSUE_SPLIT_EN
        if (w_rd_ctrl.inp_valid == 2'b11) begin
          r_inp_valid <= 2'b01;
          r_opb       <= '0;
          r_opb_hold  <= w_rd_opb;
          r_state     <= SPLIT;
        end else begin
          r_inp_valid <= w_rd_ctrl.inp_valid;
          r_opb       <= w_rd_opb;
          r_state     <= ISSUE;
        end
`else
        r_inp_valid <= w_rd_ctrl.inp_valid;
        r_opb       <= w_rd_opb;
        r_state     <= ISSUE;
`endif
      end else begin
        case (r_state)
          IDLE: r_state <= IDLE;
`ifdef ALU_ISSUE_SPLIT_EN
          SPLIT: begin
            r_inp_valid <= 2'b10;
            r_opb       <= r_opb_hold;
            r_state     <= ISSUE;
          end
`endif
          ISSUE, WAIT: begin
            if (r_strobe) begin
              r_ce        <= 1'b0;
              r_mode      <= 1'b0;
              r_cin       <= 1'b0;
              r_cmd       <= '0;
              r_inp_valid <= '0;
              r_opa       <= '0;
              r_opb       <= '0;
              r_cnt       <= '0;
              r_state     <= IDLE;
            end else begin
              r_cnt    <= r_cnt - 2'd1;
              r_strobe <= (r_cnt == 2'd1);
              r_state  <= WAIT;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.in_ready   = !w_full;
  assign bus.fifo_count = w_count;
  assign bus.ce         = r_ce;
  assign bus.mode       = r_mode;
  assign bus.cin        = r_cin;
  assign bus.cmd        = r_cmd;
  assign bus.inp_valid  = r_inp_valid;
  assign bus.opa        = r_opa;
  assign bus.opb        = r_opb;
  assign bus.res_strobe = r_strobe;
  assign bus.busy       = (r_state != IDLE);

endmodule

`default_nettype wire
